// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit adder/subtractor built from CHUNK-bit ripple segments, one register level per segment.
// Operands are registered on entry, so a result appears WIDTH/CHUNK cycles after it is accepted.
module pipelined_adder_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Level k holds an operation whose chunks 0..k-1 are already summed; level STAGES is the output.
  logic [STAGES:0]  vld;
  logic [STAGES:0]  c_r;
  logic [WIDTH-1:0] x_r   [STAGES];
  logic [WIDTH-1:0] y_r   [STAGES];
  logic [WIDTH-1:0] s_r   [STAGES+1];
  logic [CHUNK:0]   part  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             ovf_r;
  logic             ovf_nxt;
  logic             advance;

  assign advance   = !vld[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld[STAGES];
  assign sum       = s_r[STAGES];
  assign c_out     = c_r[STAGES];
  assign ovf       = ovf_r;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, x_r[k][k*CHUNK +: CHUNK]} + {1'b0, y_r[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_r[k]};
      s_nxt[k] = s_r[k];
      s_nxt[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
    end
    // Carry into the MSB equals x ^ y ^ sum at that bit, so ovf needs no extra adder tap.
    ovf_nxt = x_r[STAGES-1][WIDTH-1] ^ y_r[STAGES-1][WIDTH-1]
            ^ part[STAGES-1][CHUNK-1] ^ part[STAGES-1][CHUNK];
  end

  // Data registers only load behind a valid bit, so outputs keep their last result across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_r[k] <= '0;
        y_r[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        s_r[k] <= '0;
      end
    end else if (advance) begin
      vld <= {vld[STAGES-1:0], in_valid};
      if (in_valid) begin
        x_r[0] <= x;
        y_r[0] <= sub ? ~y : y;
        c_r[0] <= sub ^ c_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (vld[k-1]) begin
          x_r[k] <= x_r[k-1];
          y_r[k] <= y_r[k-1];
        end
      end
      for (int k = 0; k < STAGES; k++) begin
        if (vld[k]) begin
          s_r[k+1] <= s_nxt[k];
          c_r[k+1] <= part[k][CHUNK];
        end
      end
      if (vld[STAGES-1]) begin
        ovf_r <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Randomised bench for pipelined_adder_sub: default instance plus (4,4), (8,2), (32,8) sweep instances.
// Expected results come from plain integer arithmetic on the operands.
module tb_pipelined_adder_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [15:0] x, y, sum;

  logic        sw_valid, sw_cin, sw_sub, sw_out_ready;
  logic [31:0] sw_x, sw_y;
  logic        a_ready, a_valid, a_cout, a_ovf;
  logic        b_ready, b_valid, b_cout, b_ovf;
  logic        c_ready, c_valid, c_cout, c_ovf;
  logic [3:0]  a_sum;
  logic [7:0]  b_sum;
  logic [31:0] c_sum;

  pipelined_adder_sub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf));

  pipelined_adder_sub #(.WIDTH(4), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(a_ready), .x(sw_x[3:0]), .y(sw_y[3:0]),
    .c_in(sw_cin), .sub(sw_sub), .out_valid(a_valid), .out_ready(sw_out_ready),
    .sum(a_sum), .c_out(a_cout), .ovf(a_ovf));

  pipelined_adder_sub #(.WIDTH(8), .CHUNK(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(b_ready), .x(sw_x[7:0]), .y(sw_y[7:0]),
    .c_in(sw_cin), .sub(sw_sub), .out_valid(b_valid), .out_ready(sw_out_ready),
    .sum(b_sum), .c_out(b_cout), .ovf(b_ovf));

  pipelined_adder_sub #(.WIDTH(32), .CHUNK(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(c_ready), .x(sw_x), .y(sw_y),
    .c_in(sw_cin), .sub(sw_sub), .out_valid(c_valid), .out_ready(sw_out_ready),
    .sum(c_sum), .c_out(c_cout), .ovf(c_ovf));

  typedef struct {
    logic [17:0] val;
    int          edge_n;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [2:0][33:0] m;
    int               edge_n;
  } swe_t;
  swe_t ops[1000];

  // Returns {ovf, c_out, result} for a w-bit add or subtract using signed/unsigned integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic s);
    longint m, ua, ub, cl, res, sa, sb, sres;
    logic co, ov;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    cl = ci ? 1 : 0;
    if (!s) begin
      res = ua + ub + cl;
      co  = (res >= m);
    end else begin
      res = ua - ub - cl;
      co  = (res >= 0);
    end
    res  = res & (m - 1);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    sres = s ? sa - sb - cl : sa + sb + cl;
    ov   = (sres >= m / 2) || (sres < -(m / 2));
    return {ov, co, res[31:0]};
  endfunction

  function automatic logic [17:0] exp16(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    logic [33:0] r;
    r = model(16, {16'h0, a}, {16'h0, b}, ci, s);
    return {r[33], r[32], r[15:0]};
  endfunction

  task automatic drive_cycle(input logic iv, input logic [15:0] xv, input logic [15:0] yv,
                             input logic ci, input logic sb, input logic ordy,
                             output logic acc, output logic dlv, output logic [17:0] obs);
    @(negedge clk);
    in_valid  = iv;
    x         = xv;
    y         = yv;
    c_in      = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    dlv = out_valid && ordy;
    obs = {ovf, c_out, sum};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, c_out, ovf, sum} !== 19'h0)
      begin errors++; $display("FAIL reset_outputs got %h want 0", {out_valid, c_out, ovf, sum}); end
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] tx[4]   = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] ty[4]   = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        tc[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] texp[4] = '{{2'b01, 16'h0000}, {2'b10, 16'h8000},
                             {2'b00, 16'hFFFE}, {2'b11, 16'h7FFE}};
    logic acc, dlv;
    logic [17:0] obs;
    exp_t e;
    for (int i = 0; i < 20 && (i < 4 || q.size() > 0); i++) begin
      if (i < 4) drive_cycle(1'b1, tx[i], ty[i], tc[i], ts[i], 1'b1, acc, dlv, obs);
      else       drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, dlv, obs);
      if (i < 4) begin
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL dir_accept op %0d got %b want 1", i, acc); end
        else q.push_back(exp_t'{texp[i], cyc + 1});
      end
      if (dlv) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL dir_extra got %h want none", obs); end
        else begin
          e = q.pop_front();
          if (obs !== e.val) begin errors++; $display("FAIL dir_result got %h want %h", obs, e.val); end
          checks++;
          if (cyc - e.edge_n != 4)
            begin errors++; $display("FAIL dir_latency got %0d want 4", cyc - e.edge_n); end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL dir_drain got %0d left want 0", q.size()); end
    q.delete();
  endtask

  task automatic test_streaming();
    logic acc, dlv;
    logic [17:0] obs;
    logic [15:0] rx, ry;
    logic rc, rs;
    exp_t e;
    for (int i = 0; i < 130 && (i < 100 || q.size() > 0); i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      rc = 1'($urandom_range(1, 0)); rs = 1'($urandom_range(1, 0));
      drive_cycle(i < 100, rx, ry, rc, rs, 1'b1, acc, dlv, obs);
      if (i < 100) begin
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL stream_accept got %b want 1", acc); end
        else q.push_back(exp_t'{exp16(rx, ry, rc, rs), cyc + 1});
      end
      if (dlv) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stream_extra got %h want none", obs); end
        else begin
          e = q.pop_front();
          if (obs !== e.val) begin errors++; $display("FAIL stream_result got %h want %h", obs, e.val); end
          checks++;
          if (cyc - e.edge_n != 4)
            begin errors++; $display("FAIL stream_latency got %0d want 4", cyc - e.edge_n); end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL stream_drain got %0d left want 0", q.size()); end
    q.delete();
  endtask

  task automatic test_backpressure();
    logic acc, dlv, ordy, iv;
    logic [17:0] obs;
    logic [15:0] rx, ry;
    logic rc, rs;
    int stalled = 0;
    for (int i = 0; i < 20 && stalled < 6; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      rc = 1'($urandom_range(1, 0)); rs = 1'($urandom_range(1, 0));
      drive_cycle(1'b1, rx, ry, rc, rs, 1'b0, acc, dlv, obs);
      if (acc) q.push_back(exp_t'{exp16(rx, ry, rc, rs), cyc + 1});
      if (out_valid) begin
        stalled++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_frozen got %h want none", obs); end
        else if (obs !== q[0].val)
          begin errors++; $display("FAIL bp_frozen got %h want %h", obs, q[0].val); end
      end
    end
    checks++;
    if (stalled < 6) begin errors++; $display("FAIL bp_stall_timeout got %0d want 6", stalled); end
    for (int i = 0; i < 340 && (i < 300 || q.size() > 0); i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      rc = 1'($urandom_range(1, 0)); rs = 1'($urandom_range(1, 0));
      iv   = (i < 300) ? 1'($urandom_range(1, 0)) : 1'b0;
      ordy = (i < 300) ? 1'($urandom_range(1, 0)) : 1'b1;
      drive_cycle(iv, rx, ry, rc, rs, ordy, acc, dlv, obs);
      checks++;
      if (in_ready !== (out_valid ? ordy : 1'b1))
        begin errors++; $display("FAIL bp_ready got %b want %b", in_ready, out_valid ? ordy : 1'b1); end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra got %h want none", obs); end
        else if (obs !== q[0].val)
          begin errors++; $display("FAIL bp_result got %h want %h", obs, q[0].val); end
      end
      if (acc) q.push_back(exp_t'{exp16(rx, ry, rc, rs), cyc + 1});
      if (dlv && q.size() > 0) void'(q.pop_front());
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL bp_drain got %0d left want 0", q.size()); end
    q.delete();
  endtask

  task automatic test_reset_midstream();
    logic acc, dlv;
    logic [17:0] obs;
    int stale = 0;
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 16'h1234 + 16'(i), 16'h1111, 1'b0, 1'b0, 1'b0, acc, dlv, obs);
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, sum} !== {1'b1, 16'h2345})
      begin errors++; $display("FAIL mid_prefill got %b/%h want 1/2345", out_valid, sum); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, c_out, ovf, sum} !== 19'h0)
      begin errors++; $display("FAIL mid_reset_outputs got %h want 0", {out_valid, c_out, ovf, sum}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, dlv, obs);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d want 0", stale); end
  endtask

  task automatic test_sweep();
    int lat[3] = '{1, 4, 4};
    int wr = 0;
    int rd[3] = '{0, 0, 0};
    logic [2:0]  rdy, vld;
    logic [33:0] got[3];
    for (int t = 0; t < 4000; t++) begin
      if (wr >= 1000 && rd[0] == wr && rd[1] == wr && rd[2] == wr) break;
      @(negedge clk);
      sw_valid = (wr < 1000) && ($urandom_range(3, 0) != 0);
      sw_x = $urandom; sw_y = $urandom;
      sw_cin = 1'($urandom_range(1, 0)); sw_sub = 1'($urandom_range(1, 0));
      #1;
      rdy    = {c_ready, b_ready, a_ready};
      vld    = {c_valid, b_valid, a_valid};
      got[0] = {a_ovf, a_cout, 28'h0, a_sum};
      got[1] = {b_ovf, b_cout, 24'h0, b_sum};
      got[2] = {c_ovf, c_cout, c_sum};
      if (sw_valid) begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (rdy[i] !== 1'b1) begin errors++; $display("FAIL sweep_ready inst %0d got %b want 1", i, rdy[i]); end
        end
        ops[wr].m[0]  = model(4, sw_x, sw_y, sw_cin, sw_sub);
        ops[wr].m[1]  = model(8, sw_x, sw_y, sw_cin, sw_sub);
        ops[wr].m[2]  = model(32, sw_x, sw_y, sw_cin, sw_sub);
        ops[wr].edge_n = cyc + 1;
        wr++;
      end
      for (int i = 0; i < 3; i++) begin
        if (vld[i]) begin
          checks++;
          if (rd[i] >= wr) begin errors++; $display("FAIL sweep_extra inst %0d got %h want none", i, got[i]); end
          else begin
            if (got[i] !== ops[rd[i]].m[i])
              begin errors++; $display("FAIL sweep_result inst %0d got %h want %h", i, got[i], ops[rd[i]].m[i]); end
            checks++;
            if (cyc - ops[rd[i]].edge_n != lat[i])
              begin errors++; $display("FAIL sweep_latency inst %0d got %0d want %0d", i, cyc - ops[rd[i]].edge_n, lat[i]); end
            rd[i]++;
          end
        end
      end
    end
    sw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd[i] != 1000 || wr != 1000)
        begin errors++; $display("FAIL sweep_count inst %0d got %0d/%0d want 1000", i, rd[i], wr); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_x = '0; sw_y = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_out_ready = 1'b1;
    $display("[TB] starting pipelined_adder_sub bench");
    test_reset();
    test_directed();
    test_streaming();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
